// File: rtl/ooo_pkg.sv
// ooo_pkg: shared instruction-entry definitions for the out-of-order core.
// Holds field widths and the {opcode, r_a, r_b, rt} entry layout together
// with the packing helper. The instruction queue, rename and the reservation
// stations all use this layout.
package ooo_pkg;

    localparam int OPC_W   = 4;
    localparam int REG_W   = 4;
    localparam int ENTRY_W = OPC_W + 3 * REG_W;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] r_a;
        logic [REG_W-1:0] r_b;
        logic [REG_W-1:0] rt;
    } entry_t;

    function automatic entry_t pack_entry(
        input logic [OPC_W-1:0] opcode,
        input logic [REG_W-1:0] r_a,
        input logic [REG_W-1:0] r_b,
        input logic [REG_W-1:0] rt
    );
        entry_t e;
        e.opcode = opcode;
        e.r_a    = r_a;
        e.r_b    = r_b;
        e.rt     = rt;
        return e;
    endfunction

endpackage

// File: rtl/instr_queue_lane_compact.sv
// lane_compact: packs sparse enqueue lanes into consecutive queue slots.
//   in_valid  in   per-lane valid, lane 0 oldest
//   offset    out  per-lane write offset from tail (valid lanes below it)
//   total     out  popcount(in_valid)
// An invalid lane still gets an offset; the caller simply does not write it.
module lane_compact #(
    parameter int ENQ_W = 4,
    parameter int OFS_W = (ENQ_W > 1) ? $clog2(ENQ_W) : 1,
    parameter int TOT_W = $clog2(ENQ_W + 1)
) (
    input  logic [ENQ_W-1:0]            in_valid,
    output logic [ENQ_W-1:0][OFS_W-1:0] offset,
    output logic [TOT_W-1:0]            total
);

    logic [TOT_W-1:0] acc;

    // Exclusive prefix popcount: lane i lands at tail + (valid lanes below i).
    always_comb begin
        acc = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            offset[i] = acc[OFS_W-1:0];
            acc       = acc + TOT_W'(in_valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/instr_queue.sv
// instr_queue: in-order instruction queue between decode and rename.
// Circular buffer of DEPTH entries, up to ENQ_W sparse lanes written per
// cycle (compacted in lane order), oldest DEQ_W entries presented to the
// consumer. Single-cycle flush; rst acts like flush with priority.
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               discard all entries on the next edge
//   in_valid, in_*      enqueue lanes (lane i at [i*W +: W])
//   in_ready            all-or-nothing accept, from registered count only
//   out_valid, out_*    head entries, thermometer valid, lane 0 oldest
//   deq_num             head entries consumed this cycle
//   count               current occupancy
module instr_queue
    import ooo_pkg::*;
#(
    parameter int ENQ_W = 4,
    parameter int DEQ_W = 2,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int DQN_W = $clog2(DEQ_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [ENQ_W-1:0]       in_valid,
    input  logic [ENQ_W*OPC_W-1:0] in_opcode,
    input  logic [ENQ_W*REG_W-1:0] in_r_a,
    input  logic [ENQ_W*REG_W-1:0] in_r_b,
    input  logic [ENQ_W*REG_W-1:0] in_rt,
    output logic                   in_ready,
    output logic [DEQ_W-1:0]       out_valid,
    output logic [DEQ_W*OPC_W-1:0] out_opcode,
    output logic [DEQ_W*REG_W-1:0] out_r_a,
    output logic [DEQ_W*REG_W-1:0] out_r_b,
    output logic [DEQ_W*REG_W-1:0] out_rt,
    input  logic [DQN_W-1:0]       deq_num,
    output logic [CNT_W-1:0]       count
);

    localparam int OFS_W = (ENQ_W > 1) ? $clog2(ENQ_W) : 1;
    localparam int TOT_W = $clog2(ENQ_W + 1);

    entry_t                        mem [DEPTH];
    logic [PTR_W-1:0]              head, tail;
    logic [ENQ_W-1:0][OFS_W-1:0]   offset;
    logic [TOT_W-1:0]              total;
    logic                          accept;
    logic [CNT_W-1:0]              enq_cnt, deq_req, deq_eff;

    lane_compact #(.ENQ_W(ENQ_W)) u_compact (
        .in_valid (in_valid),
        .offset   (offset),
        .total    (total)
    );

    // Freed slots only count once they show up in the registered count.
    assign in_ready = (count <= CNT_W'(DEPTH - ENQ_W));
    assign accept   = in_ready && (|in_valid);
    assign enq_cnt  = accept ? CNT_W'(total) : '0;

    // Consuming more than is present is a protocol error; never underflow.
    assign deq_req  = CNT_W'(deq_num);
    assign deq_eff  = (deq_req > count) ? count : deq_req;

    // Storage is deliberately not reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (accept && !rst && !flush) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (in_valid[i]) begin
                    mem[tail + PTR_W'(offset[i])] <= pack_entry(
                        in_opcode[i*OPC_W +: OPC_W], in_r_a[i*REG_W +: REG_W],
                        in_r_b[i*REG_W +: REG_W],    in_rt[i*REG_W +: REG_W]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(enq_cnt);
            head  <= head + PTR_W'(deq_eff);
            count <= count + enq_cnt - deq_eff;
        end
    end

    // Head lanes read straight from storage; pointer wrap is natural.
    for (genvar j = 0; j < DEQ_W; j++) begin : g_out
        entry_t rd;
        assign rd                          = mem[head + PTR_W'(j)];
        assign out_valid[j]                = (count > CNT_W'(j));
        assign out_opcode[j*OPC_W +: OPC_W] = rd.opcode;
        assign out_r_a[j*REG_W +: REG_W]   = rd.r_a;
        assign out_r_b[j*REG_W +: REG_W]   = rd.r_b;
        assign out_rt[j*REG_W +: REG_W]    = rd.rt;
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed steps then a random mix, checked every cycle
// against a plain FIFO (SystemVerilog queue) reference model.
module tb_instr_queue;

    localparam int ENQ_W = 4;
    localparam int DEQ_W = 2;
    localparam int DEPTH = 16;
    localparam int OPC_W = 4;
    localparam int REG_W = 4;
    localparam int EW    = OPC_W + 3 * REG_W;

    logic                   clk = 1'b0;
    logic                   rst, flush;
    logic [ENQ_W-1:0]       in_valid;
    logic [ENQ_W*OPC_W-1:0] in_opcode;
    logic [ENQ_W*REG_W-1:0] in_r_a, in_r_b, in_rt;
    logic                   in_ready;
    logic [DEQ_W-1:0]       out_valid;
    logic [DEQ_W*OPC_W-1:0] out_opcode;
    logic [DEQ_W*REG_W-1:0] out_r_a, out_r_b, out_rt;
    logic [1:0]             deq_num;
    logic [4:0]             count;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] model [$];

    instr_queue #(.ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_r_a(in_r_a),
        .in_r_b(in_r_b), .in_rt(in_rt), .in_ready(in_ready),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_r_a(out_r_a),
        .out_r_b(out_r_b), .out_rt(out_rt), .deq_num(deq_num), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        int n;
        logic [EW-1:0] got;
        n = model.size();
        checks++;
        assert (count === 5'(n)) else begin
            errors++; $error("FAIL %s count got %0d exp %0d", tag, count, n);
        end
        checks++;
        assert (in_ready === ((DEPTH - n) >= ENQ_W)) else begin
            errors++; $error("FAIL %s in_ready got %0b exp %0b", tag, in_ready, (DEPTH - n) >= ENQ_W);
        end
        for (int j = 0; j < DEQ_W; j++) begin
            checks++;
            assert (out_valid[j] === (n > j)) else begin
                errors++; $error("FAIL %s out_valid[%0d] got %0b exp %0b", tag, j, out_valid[j], n > j);
            end
            if (n > j) begin
                got = {out_opcode[j*OPC_W +: OPC_W], out_r_a[j*REG_W +: REG_W],
                       out_r_b[j*REG_W +: REG_W], out_rt[j*REG_W +: REG_W]};
                checks++;
                assert (got === model[j]) else begin
                    errors++; $error("FAIL %s lane%0d entry got %h exp %h", tag, j, got, model[j]);
                end
            end
        end
    endtask

    // Drive one cycle at the negedge, update the model, check after the edge.
    task automatic cycle(input logic [ENQ_W-1:0] v, input logic [ENQ_W-1:0][EW-1:0] d,
                         input int dq, input bit fl, input bit rs, input string tag);
        bit rdy;
        rst = rs; flush = fl; in_valid = v; deq_num = 2'(dq);
        for (int i = 0; i < ENQ_W; i++) begin
            in_opcode[i*OPC_W +: OPC_W] = d[i][EW-1 -: OPC_W];
            in_r_a[i*REG_W +: REG_W]    = d[i][3*REG_W-1 -: REG_W];
            in_r_b[i*REG_W +: REG_W]    = d[i][2*REG_W-1 -: REG_W];
            in_rt[i*REG_W +: REG_W]     = d[i][REG_W-1:0];
        end
        rdy = (DEPTH - model.size()) >= ENQ_W;
        if (rs || fl) begin
            model.delete();
        end else begin
            for (int k = 0; k < dq; k++) void'(model.pop_front());
            if (rdy)
                for (int i = 0; i < ENQ_W; i++)
                    if (v[i]) model.push_back(d[i]);
        end
        @(posedge clk);
        @(negedge clk);
        check(tag);
    endtask

    function automatic logic [ENQ_W-1:0][EW-1:0] rnd_data();
        logic [ENQ_W-1:0][EW-1:0] d;
        for (int i = 0; i < ENQ_W; i++) d[i] = EW'($urandom);
        return d;
    endfunction

    function automatic int legal_deq(input int want);
        int lim;
        lim = (model.size() < DEQ_W) ? model.size() : DEQ_W;
        return (want < lim) ? want : lim;
    endfunction

    initial begin
        logic [ENQ_W-1:0][EW-1:0] d;
        int pushed;
        rst = 1'b1; flush = 1'b0; in_valid = '0; deq_num = '0;
        in_opcode = '0; in_r_a = '0; in_r_b = '0; in_rt = '0;
        @(negedge clk);
        cycle('0, rnd_data(), 0, 1'b0, 1'b1, "reset");
        checks++;
        assert (count === 5'd0 && out_valid === 2'b00 && in_ready === 1'b1) else begin
            errors++; $error("FAIL reset_state count %0d out_valid %b in_ready %b exp 0 00 1", count, out_valid, in_ready);
        end

        // Full-width enqueue, opcodes 1..4.
        d = rnd_data();
        for (int i = 0; i < ENQ_W; i++) d[i][EW-1 -: OPC_W] = 4'(i + 1);
        cycle(4'b1111, d, 0, 1'b0, 1'b0, "enq4");
        checks++;
        assert (out_opcode === 8'h21) else begin
            errors++; $error("FAIL enq4_opcodes got %h exp 21", out_opcode);
        end

        // Sparse lanes 1 and 3 into an empty queue.
        cycle('0, rnd_data(), 0, 1'b1, 1'b0, "flush_a");
        d = rnd_data();
        d[1][EW-1 -: OPC_W] = 4'hA;
        d[3][EW-1 -: OPC_W] = 4'hB;
        cycle(4'b1010, d, 0, 1'b0, 1'b0, "sparse");
        checks++;
        assert (out_opcode === 8'hBA) else begin
            errors++; $error("FAIL sparse_opcodes got %h exp BA", out_opcode);
        end

        // Fill to 13: blocked enqueue ignored, one dequeue reopens in_ready.
        cycle('0, rnd_data(), 0, 1'b1, 1'b0, "flush_b");
        for (int k = 0; k < 3; k++) cycle(4'b1111, rnd_data(), 0, 1'b0, 1'b0, "fill");
        cycle(4'b0100, rnd_data(), 0, 1'b0, 1'b0, "fill13");
        cycle(4'b1111, rnd_data(), 0, 1'b0, 1'b0, "blocked");
        checks++;
        assert (count === 5'd13 && in_ready === 1'b0) else begin
            errors++; $error("FAIL blocked count %0d in_ready %b exp 13 0", count, in_ready);
        end
        cycle('0, rnd_data(), 1, 1'b0, 1'b0, "deq1");
        checks++;
        assert (count === 5'd12 && in_ready === 1'b1) else begin
            errors++; $error("FAIL reopen count %0d in_ready %b exp 12 1", count, in_ready);
        end

        // Wrap: move head/tail to 14, then enqueue 4 across index 15 -> 0.
        cycle('0, rnd_data(), 0, 1'b1, 1'b0, "flush_c");
        pushed = 0;
        while (pushed < 14) begin
            cycle((pushed < 12) ? 4'b1111 : 4'b0011, rnd_data(), legal_deq(2), 1'b0, 1'b0, "to14");
            pushed += (pushed < 12) ? 4 : 2;
        end
        while (model.size() > 0) cycle('0, rnd_data(), legal_deq(2), 1'b0, 1'b0, "drain14");
        cycle(4'b1111, rnd_data(), 0, 1'b0, 1'b0, "wrap_enq");
        while (model.size() > 0) cycle('0, rnd_data(), legal_deq(2), 1'b0, 1'b0, "wrap_deq");

        // Flush at count 7 with enqueue and dequeue in the same cycle.
        cycle(4'b1111, rnd_data(), 0, 1'b0, 1'b0, "pre_fl");
        cycle(4'b0111, rnd_data(), 0, 1'b0, 1'b0, "pre_fl7");
        cycle(4'b1111, rnd_data(), 2, 1'b1, 1'b0, "flush7");
        checks++;
        assert (count === 5'd0 && out_valid === 2'b00) else begin
            errors++; $error("FAIL flush7 count %0d out_valid %b exp 0 00", count, out_valid);
        end
        cycle(4'b0001, rnd_data(), 0, 1'b0, 1'b0, "post_fl");

        // Random mix with a mid-run reset and occasional flushes.
        for (int c = 0; c < 10000; c++) begin
            cycle(4'($urandom), rnd_data(), legal_deq(int'($urandom_range(0, 2))),
                  ($urandom_range(0, 99) < 2), (c == 5000), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
